control_sequencer: RTL and testbench

//  Moore/Mealy control unit that drives the Datapath's bus-enable, register-load and ALU

---
 rtl/control_sequencer_if.sv | 43 ++++
 rtl/control_sequencer.sv | 139 +++++++++++++
 tb/tb_control_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer and the Datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
);
  logic                Run;
  logic                Mem_Ready;
  logic [31:0]         IR;
  logic                PC_Out;
  logic                MDR_Out;
  logic                ZLO_Out;
  logic                PC_In;
  logic                MDR_In;
  logic                MAR_In;
  logic                IR_In;
  logic                Y_In;
  logic                ZLO_In;
  logic                IncPC;
  logic                Read;
  logic [OP_W-1:0]     CONTROL;
  logic [NUM_REGS-1:0] R_In;
  logic [NUM_REGS-1:0] R_Out;
  logic                Running;
  logic                Illegal;
  logic                Halted;

  modport master (
    input  Run, Mem_Ready, IR,
    output PC_Out, MDR_Out, ZLO_Out,
    output PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In,
    output IncPC, Read, CONTROL, R_In, R_Out,
    output Running, Illegal, Halted
  );

  modport slave (
    output Run, Mem_Ready, IR,
    input  PC_Out, MDR_Out, ZLO_Out,
    input  PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In,
    input  IncPC, Read, CONTROL, R_In, R_Out,
    input  Running, Illegal, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch / reg-reg ALU execute sequencer driving Datapath control lines.
// T1 waits on Mem_Ready with a timeout into a sticky FAULT state.
module control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5,
  parameter int RF_W     = 4,
  parameter int TIMEOUT  = 15
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RA_HI = 31 - OP_W;
  localparam int RB_HI = RA_HI - RF_W;
  localparam int RC_HI = RB_HI - RF_W;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [OP_W-1:0] op;
  logic [RF_W-1:0] ra, rb, rc;
  logic            is_alu, is_halt;
  logic            unused_ir;

  assign op      = bus.IR[31 -: OP_W];
  assign ra      = bus.IR[RA_HI -: RF_W];
  assign rb      = bus.IR[RB_HI -: RF_W];
  assign rc      = bus.IR[RC_HI -: RF_W];
  assign is_alu  = (op >= OP_ADD) && (op <= OP_OR);
  assign is_halt = (op == OP_HALT);
  assign unused_ir = ^bus.IR[RC_HI-RF_W:0];

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus.PC_Out  = 1'b0;
    bus.MDR_Out = 1'b0;
    bus.ZLO_Out = 1'b0;
    bus.PC_In   = 1'b0;
    bus.MDR_In  = 1'b0;
    bus.MAR_In  = 1'b0;
    bus.IR_In   = 1'b0;
    bus.Y_In    = 1'b0;
    bus.ZLO_In  = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.CONTROL = '0;
    bus.R_In    = '0;
    bus.R_Out   = '0;
    bus.Running = 1'b0;
    bus.Illegal = 1'b0;
    bus.Halted  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Run) state_d = S_T0;
      end
      S_T0: begin
        bus.Running = 1'b1;
        bus.PC_Out  = 1'b1;
        bus.MAR_In  = 1'b1;
        bus.IncPC   = 1'b1;
        bus.ZLO_In  = 1'b1;
        state_d     = S_T1;
      end
      S_T1: begin
        bus.Running = 1'b1;
        bus.Read    = 1'b1;
        bus.MDR_In  = 1'b1;
        if (bus.Mem_Ready) begin
          // incremented PC comes back from Z only once the fetch lands
          bus.ZLO_Out = 1'b1;
          bus.PC_In   = 1'b1;
          cnt_d       = '0;
          state_d     = S_T2;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) state_d = S_FAULT;
        end
      end
      S_T2: begin
        bus.Running = 1'b1;
        bus.MDR_Out = 1'b1;
        bus.IR_In   = 1'b1;
        state_d     = S_T3;
      end
      S_T3: begin
        bus.Running = 1'b1;
        if (is_alu) begin
          bus.R_Out = ONE << rb;
          bus.Y_In  = 1'b1;
          state_d   = S_T4;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          bus.Illegal = 1'b1;
          state_d     = bus.Run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        bus.Running = 1'b1;
        bus.R_Out   = ONE << rc;
        bus.ZLO_In  = 1'b1;
        bus.CONTROL = op - OP_W'(1);
        state_d     = S_T5;
      end
      S_T5: begin
        bus.Running = 1'b1;
        bus.ZLO_Out = 1'b1;
        bus.R_In    = ONE << ra;
        state_d     = bus.Run ? S_T0 : S_IDLE;
      end
      S_HALT, S_FAULT: begin
        bus.Halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected output
// vectors are queued with each stimulus step and checked at negedge.
module tb_control_sequencer;
  logic Clock;
  logic Clear;

  control_sequencer_if #(.NUM_REGS(16), .OP_W(5)) bus ();

  control_sequencer #(
    .NUM_REGS(16), .OP_W(5), .RF_W(4), .TIMEOUT(15)
  ) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus  (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef logic [50:0] ov_t;
  typedef struct {
    logic        run;
    logic        rdy;
    logic [31:0] ir;
  } stim_t;

  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] MDRO = 14'h1000;
  localparam logic [13:0] ZLOO = 14'h0800;
  localparam logic [13:0] PCI  = 14'h0400;
  localparam logic [13:0] MDRI = 14'h0200;
  localparam logic [13:0] MARI = 14'h0100;
  localparam logic [13:0] IRI  = 14'h0080;
  localparam logic [13:0] YI   = 14'h0040;
  localparam logic [13:0] ZLOI = 14'h0020;
  localparam logic [13:0] INC  = 14'h0010;
  localparam logic [13:0] RD   = 14'h0008;
  localparam logic [13:0] RUN  = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002;
  localparam logic [13:0] HLT  = 14'h0001;

  stim_t sq[$];
  ov_t   eq[$];
  int    total;
  int    bad;

  function automatic ov_t sample();
    return {bus.PC_Out, bus.MDR_Out, bus.ZLO_Out, bus.PC_In,
            bus.MDR_In, bus.MAR_In, bus.IR_In, bus.Y_In,
            bus.ZLO_In, bus.IncPC, bus.Read, bus.Running,
            bus.Illegal, bus.Halted, bus.CONTROL,
            bus.R_In, bus.R_Out};
  endfunction

  function automatic void push(
    input logic run, input logic rdy, input logic [31:0] ir,
    input logic [13:0] f, input logic [4:0] c,
    input logic [15:0] ri, input logic [15:0] ro
  );
    stim_t s;
    s.run = run;
    s.rdy = rdy;
    s.ir  = ir;
    sq.push_back(s);
    eq.push_back({f, c, ri, ro});
  endfunction

  function automatic void push_fetch(input logic [31:0] ir, input int waits);
    push(1'b1, 1'b1, ir, PCO | MARI | INC | ZLOI | RUN, 5'd0, 16'h0, 16'h0);
    for (int i = 0; i < waits; i++)
      push(1'b1, 1'b0, ir, RD | MDRI | RUN, 5'd0, 16'h0, 16'h0);
    push(1'b1, 1'b1, ir, RD | MDRI | ZLOO | PCI | RUN, 5'd0, 16'h0, 16'h0);
    push(1'b1, 1'b1, ir, MDRO | IRI | RUN, 5'd0, 16'h0, 16'h0);
  endfunction

  function automatic void push_exec(
    input logic [31:0] ir, input logic run3, input logic run5
  );
    logic [15:0] one;
    logic [4:0]  op;
    one = 16'h1;
    op  = ir[31:27];
    push(run3, 1'b1, ir, YI | RUN, 5'd0, 16'h0, one << ir[22:19]);
    push(run3, 1'b1, ir, ZLOI | RUN, op - 5'd1, 16'h0, one << ir[18:15]);
    push(run5, 1'b1, ir, ZLOO | RUN, 5'd0, one << ir[26:23], 16'h0);
  endfunction

  task automatic drive_step();
    stim_t s;
    s = sq.pop_front();
    @(negedge Clock);
    bus.Run       = s.run;
    bus.Mem_Ready = s.rdy;
    bus.IR        = s.ir;
  endtask

  task automatic test_reset();
    ov_t o;
    Clear = 1'b1;
    bus.Run = 1'b1;
    bus.Mem_Ready = 1'b1;
    bus.IR = 32'h38A98000;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset: got %h want 0", o);
    end
    bus.Run = 1'b0;
    Clear = 1'b0;
  endtask

  task automatic test_basic_ror();
    ov_t o, e;
    int  n = 0;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push_fetch(32'h38A98000, 0);
    push_exec(32'h38A98000, 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h38A98000, 14'h0, 5'd0, 16'h0, 16'h0);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic_ror cyc %0d: got %h want %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_wait_states();
    ov_t o, e;
    int  n = 0;
    int  reads = 0;
    int  pcins = 0;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push_fetch(32'h1A448000, 3);
    push_exec(32'h1A448000, 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      if (bus.Read === 1'b1) reads++;
      if (bus.PC_In === 1'b1) pcins++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wait_states cyc %0d: got %h want %h", n, o, e);
      end
      n++;
    end
    total++;
    if (reads !== 4 || pcins !== 1) begin
      bad++;
      $display("FAIL wait_counts: reads=%0d pc_in=%0d want 4 and 1",
               reads, pcins);
    end
  endtask

  task automatic test_timeout();
    ov_t o, e;
    int  n = 0;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push(1'b1, 1'b1, 32'h0, PCO | MARI | INC | ZLOI | RUN, 5'd0, 16'h0, 16'h0);
    for (int i = 0; i < 15; i++)
      push(1'b1, 1'b0, 32'h0, RD | MDRI | RUN, 5'd0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      push(i[0], 1'b1, 32'h0, HLT, 5'd0, 16'h0, 16'h0);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL timeout cyc %0d: got %h want %h", n, o, e);
      end
      n++;
    end
    @(negedge Clock);
    Clear = 1'b1;
    bus.Run = 1'b0;
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL fault_clear: got %h want 0", o);
    end
    @(negedge Clock);
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL fault_idle: got %h want 0", o);
    end
  endtask

  task automatic test_illegal_halt();
    ov_t o, e;
    int  n = 0;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push_fetch(32'hFFFFFFFF, 0);
    push(1'b1, 1'b1, 32'hFFFFFFFF, ILL | RUN, 5'd0, 16'h0, 16'h0);
    push_fetch(32'hD8A98000, 1);
    push(1'b1, 1'b1, 32'hD8A98000, RUN, 5'd0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++)
      push(i[0], 1'b1, 32'hD8A98000, HLT, 5'd0, 16'h0, 16'h0);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL illegal_halt cyc %0d: got %h want %h", n, o, e);
      end
      n++;
    end
    @(negedge Clock);
    Clear = 1'b1;
    bus.Run = 1'b0;
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL halt_clear: got %h want 0", o);
    end
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic test_run_drop();
    ov_t o, e;
    int  n = 0;
    logic [15:0] one;
    one = 16'h1;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push_fetch(32'h4B1A0000, 0);
    push_exec(32'h4B1A0000, 1'b0, 1'b0);
    push(1'b0, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push(1'b0, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    push_fetch(32'h1A448000, 0);
    push(1'b1, 1'b1, 32'h1A448000, YI | RUN, 5'd0, 16'h0, one << 4'd8);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL run_drop cyc %0d: got %h want %h", n, o, e);
      end
      n++;
    end
    eq.push_back({ZLOI | RUN, 5'd2, 16'h0, one << 4'd9});
    @(negedge Clock);
    #1;
    e = eq.pop_front();
    o = sample();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL t4_before_clear: got %h want %h", o, e);
    end
    Clear = 1'b1;
    bus.Run = 1'b0;
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL async_clear_t4: got %h want 0", o);
    end
    @(posedge Clock);
    #1;
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    o = sample();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL idle_after_clear: got %h want 0", o);
    end
  endtask

  task automatic test_random_stream();
    ov_t o, e;
    int  n = 0;
    logic [31:0] ir;
    logic [4:0]  op;
    push(1'b1, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    for (int k = 0; k < 20; k++) begin
      op = 5'($urandom_range(3, 10));
      ir = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      push_fetch(ir, int'($urandom_range(0, 3)));
      push_exec(ir, 1'b1, (k != 19));
    end
    push(1'b0, 1'b1, 32'h0, 14'h0, 5'd0, 16'h0, 16'h0);
    while (eq.size() != 0) begin
      drive_step();
      #1;
      e = eq.pop_front();
      o = sample();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random cyc %0d: got %h want %h", n, o, e);
      end
      total++;
      if ($countones({bus.PC_Out, bus.MDR_Out, bus.ZLO_Out, bus.R_Out}) > 1) begin
        bad++;
        $display("FAIL bus_onehot cyc %0d: drivers=%0d want <=1", n,
                 $countones({bus.PC_Out, bus.MDR_Out, bus.ZLO_Out, bus.R_Out}));
      end
      total++;
      if ($countones(bus.R_In) > 1) begin
        bad++;
        $display("FAIL rin_onehot cyc %0d: got %h want <=1 bit", n, bus.R_In);
      end
      total++;
      if (bus.CONTROL != 5'd0 && !(bus.ZLO_In && bus.R_Out != 16'h0)) begin
        bad++;
        $display("FAIL control_t4 cyc %0d: got %h outside T4 want 0",
                 n, bus.CONTROL);
      end
      n++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.Run = 1'b0;
    bus.Mem_Ready = 1'b0;
    bus.IR = 32'h0;
    Clear = 1'b1;
    test_reset();
    test_basic_ror();
    test_wait_states();
    test_timeout();
    test_illegal_halt();
    test_run_drop();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
